sr_bank_writer: RTL and testbench
=================================

// Module: sr_bank_writer
// PURPOSE
// - Driver side of the SR flip-flop interface: converts a requested WIDTH-bit target word into
//   per-lane S/R/enable sequences for a bank of clock-gated SR flip-flops (Q samples {S,R} on the
//   rising edge of clock&e).
// - Keeps a shadow copy of the bank contents and sequences lanes LSB-first with setup/strobe/hold
//   phases. With FORCE clear, only lanes whose value changes are written.
// - Sits between a register-write requester (valid/ready) and the SR bank.
// PARAMETERS
// - WIDTH  default 4  number of SR lanes driven (>=1)
// PORTS
// - clock       in   1      single system clock, rising edge
// - reset       in   1      asynchronous, active-high reset
// - req_valid   in   1      write request present
// - req_ready   out  1      block can accept a request (IDLE only)
// - req_data    in   WIDTH  target word for the bank
// - req_force   in   1      1: write every lane regardless of shadow
// - sr_s        out  WIDTH  S lines to bank, one per lane
// - sr_r        out  WIDTH  R lines to bank, one per lane
// - sr_e        out  WIDTH  enable lines to bank, at most one bit high at a time
// - busy        out  1      sequence in progress (not IDLE)
// - done        out  1      one-cycle pulse: sequence complete
// - shadow_q    out  WIDTH  believed current bank contents
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, req_ready=1, sr_s=sr_r=sr_e=0, busy=0, done=0,
//   shadow_q=0. Zero matches the power-up Q=0 of the bank.
// - Outputs are registered; req_ready=1 exactly in IDLE.
// - Accept on req_valid&&req_ready: latch req_data/req_force, lane index idx=0, go SCAN.
//   req_* are ignored at all other times.
// - SCAN (1 cycle): if force or target[idx]!=shadow_q[idx] -> SETUP. Otherwise go to ADVANCE.
// - SETUP (1 cycle): drive lane idx: target=1 -> sr_s[idx]=1, sr_r[idx]=0.
//   Target=0 -> sr_s[idx]=0, sr_r[idx]=1. sr_e=0.
// - STROBE (1 cycle): S/R held; sr_e[idx]=1.
// - HOLD (1 cycle): S/R held, sr_e=0. At exit, shadow_q[idx]<=target[idx] and all S/R lines clear.
// - ADVANCE (combined with the exit of SCAN or HOLD, no extra cycle):
//   - idx==WIDTH-1 -> DONE.
//   - Otherwise idx++ -> SCAN.
// - DONE (1 cycle): done=1, busy=1. Next state is IDLE.
// - Latency: the first SCAN is the cycle after accept. Total = WIDTH + 3*(lanes written) + 1
//   cycles, DONE included; done is high in the last of these cycles.
// - Invariants: sr_s&sr_r==0 always; S/R lines are non-zero only on lane idx in SETUP/STROBE/HOLD;
//   $onehot0(sr_e).
// - Reset mid-sequence: abort immediately to reset values; shadow_q clears to 0. The system must
//   reset the bank with the same event, otherwise shadow and bank diverge.
// - Back-to-back: the earliest next accept is the cycle after DONE (IDLE).
// - A write to a lane already equal to its target, with force=1, still issues the full 3-cycle
//   write.
// STRUCTURE
// - Package sr_bank_pkg: state encoding constants (IDLE, SCAN, SETUP, STROBE, HOLD, DONE) and the
//   phase length constant (3).
// - Sub-module lane_onehot_decoder: idx -> WIDTH-bit one-hot, used to gate sr_s/sr_r/sr_e.
// - Remaining logic (FSM, idx counter, shadow register) stays in this module.
// TESTING (WIDTH=4)
// - Reset: assert reset mid-cycle -> all outputs 0 asynchronously, shadow_q=0, req_ready=1 after
//   release.
// - From shadow 0, write 4'b1010, force=0 -> lanes 1 and 3 each get sr_s=1 and one sr_e pulse;
//   done exactly 11 cycles after accept; shadow_q=4'b1010.
// - Then write 4'b0010 -> only lane 3 is written, with sr_r[3]=1 and one sr_e[3] pulse; done after
//   8 cycles; shadow_q=4'b0010.
// - Write equal value 4'b0010, force=0 -> no sr_e activity; done after 5 cycles. With force=1 ->
//   four writes, done after 17 cycles.
// - Hold req_valid high with changing req_data while busy -> ignored; req_ready=0 until IDLE.
//   The next accept occurs the cycle after done.
// - Assert reset during STROBE of lane 2 -> sr_e/sr_s/sr_r drop at once, shadow_q=0, and no done
//   pulse. All runs: assertion that sr_s&sr_r never becomes non-zero.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR flip-flop bank writer: FSM state encoding and
// write-phase timing.
package sr_bank_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Cycles spent on one written lane: SETUP, STROBE, HOLD.
    localparam int PHASE_LEN = 3;

    // Total sequence length from first SCAN through DONE.
    function automatic int seq_cycles(input int width, input int lanes_written);
        return width + PHASE_LEN * lanes_written + 1;
    endfunction

endpackage

// File: rtl/lane_onehot_decoder.sv
// Lane index to one-hot lane mask; out-of-range indices give an all-zero mask.
module lane_onehot_decoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [WIDTH-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_onehot[i] = (i_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/sr_bank_writer.sv
// Sequences a target word into a bank of clock-gated SR flip-flops, one lane at
// a time LSB-first, writing only lanes that differ from the shadow unless forced.
module sr_bank_writer
    import sr_bank_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_force,
    output logic [WIDTH-1:0] sr_s,
    output logic [WIDTH-1:0] sr_r,
    output logic [WIDTH-1:0] sr_e,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow_q
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [WIDTH-1:0] r_target;
    logic             r_force;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_next;

    logic [WIDTH-1:0] r_sr_s;
    logic [WIDTH-1:0] r_sr_r;
    logic [WIDTH-1:0] r_sr_e;
    logic             r_req_ready;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_lane;
    logic [WIDTH-1:0] w_sr_s_next;
    logic [WIDTH-1:0] w_sr_r_next;
    logic [WIDTH-1:0] w_sr_e_next;
    logic             w_accept;
    logic             w_hit;
    logic             w_last;
    logic             w_drive;

    lane_onehot_decoder #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_lane_dec (
        .i_idx   (r_idx),
        .o_onehot(w_lane)
    );

    assign w_accept = req_valid && r_req_ready;
    assign w_hit    = r_force || (r_target[r_idx] != r_shadow[r_idx]);
    assign w_last   = (r_idx == IDX_W'(WIDTH - 1));

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_shadow_next = r_shadow;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_SCAN;
                    w_idx_next   = '0;
                end
            end
            ST_SCAN: begin
                if (w_hit) begin
                    w_state_next = ST_SETUP;
                end else if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SCAN;
                    w_idx_next   = r_idx + IDX_W'(1);
                end
            end
            ST_SETUP:  w_state_next = ST_STROBE;
            ST_STROBE: w_state_next = ST_HOLD;
            ST_HOLD: begin
                // The lane is committed once its strobe has been followed by a hold cycle.
                w_shadow_next[r_idx] = r_target[r_idx];
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SCAN;
                    w_idx_next   = r_idx + IDX_W'(1);
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase

        // idx is stable across SETUP/STROBE/HOLD, so the current decode is the driven lane.
        w_drive     = (w_state_next == ST_SETUP) || (w_state_next == ST_STROBE) ||
                      (w_state_next == ST_HOLD);
        w_sr_s_next = (w_drive &&  r_target[r_idx]) ? w_lane : '0;
        w_sr_r_next = (w_drive && !r_target[r_idx]) ? w_lane : '0;
        w_sr_e_next = (w_state_next == ST_STROBE) ? w_lane : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_target    <= '0;
            r_force     <= 1'b0;
            r_shadow    <= '0;
            r_sr_s      <= '0;
            r_sr_r      <= '0;
            r_sr_e      <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_shadow    <= w_shadow_next;
            r_sr_s      <= w_sr_s_next;
            r_sr_r      <= w_sr_r_next;
            r_sr_e      <= w_sr_e_next;
            r_req_ready <= (w_state_next == ST_IDLE);
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= (w_state_next == ST_DONE);
            if (w_accept) begin
                r_target <= req_data;
                r_force  <= req_force;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign sr_s      = r_sr_s;
    assign sr_r      = r_sr_r;
    assign sr_e      = r_sr_e;
    assign busy      = r_busy;
    assign done      = r_done;
    assign shadow_q  = r_shadow;

endmodule

// File: tb/tb_sr_bank_writer.sv
// Randomised scoreboard bench for sr_bank_writer: a word-level model predicts
// each sequence's written lanes, polarity, latency and final shadow.
module tb_sr_bank_writer;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_data;
    logic         req_force;
    logic [W-1:0] sr_s;
    logic [W-1:0] sr_r;
    logic [W-1:0] sr_e;
    logic         busy;
    logic         done;
    logic [W-1:0] shadow_q;

    sr_bank_writer #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_force(req_force),
        .sr_s     (sr_s),
        .sr_r     (sr_r),
        .sr_e     (sr_e),
        .busy     (busy),
        .done     (done),
        .shadow_q (shadow_q)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] wr;
        logic [W-1:0] set;
        logic [W-1:0] clr;
        logic [W-1:0] shadow;
        int           lat;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_shadow;
    int           n_chk  = 0;
    int           n_fail = 0;

    function automatic int popc(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Word-level model: lanes written are those that differ (or all, if forced).
    task automatic push_exp(input logic [W-1:0] d, input logic f);
        exp_t e;
        e.wr     = f ? {W{1'b1}} : (d ^ m_shadow);
        e.set    = e.wr & d;
        e.clr    = e.wr & ~d;
        e.shadow = d;
        e.lat    = W + 3 * popc(e.wr) + 1;
        m_shadow = d;
        exp_q.push_back(e);
    endtask

    // Monitor: invariants every cycle, sequence summary compared at each done.
    int           cyc = 0;
    int           acc_cyc = 0;
    int           e_cnt = 0;
    bit           in_seq = 0;
    logic [W-1:0] e_mask, s_mask, r_mask;

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            chk("s_and_r_zero", 32'(sr_s & sr_r), 0);
            chk("sr_e_onehot0", 32'($onehot0(sr_e)), 1);
            chk("sr_lines_onehot0", 32'($onehot0(sr_s | sr_r)), 1);
            chk("ready_is_not_busy", 32'(req_ready), 32'(!busy));
            if (sr_e != 0) chk("strobe_lane_driven", 32'(sr_s | sr_r), 32'(sr_e));
            if (in_seq) begin
                if (sr_e != 0) e_cnt++;
                e_mask |= sr_e;
                s_mask |= sr_e & sr_s;
                r_mask |= sr_e & sr_r;
            end else begin
                chk("idle_sr_e", 32'(sr_e), 0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - acc_cyc, e.lat);
                    chk("strobed_lanes", 32'(e_mask), 32'(e.wr));
                    chk("strobe_count", e_cnt, popc(e.wr));
                    chk("set_lanes", 32'(s_mask), 32'(e.set));
                    chk("reset_lanes", 32'(r_mask), 32'(e.clr));
                    chk("shadow_at_done", 32'(shadow_q), 32'(e.shadow));
                    chk("busy_at_done", 32'(busy), 1);
                end
                in_seq = 0;
            end
            if (req_valid && req_ready) begin
                in_seq  = 1;
                acc_cyc = cyc;
                e_cnt   = 0;
                e_mask  = '0;
                s_mask  = '0;
                r_mask  = '0;
            end
        end else begin
            in_seq = 0;
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1;
                return;
            end
        end
        chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [W-1:0] d, input logic f);
        bit ok;
        @(posedge clock); #1;
        req_valid = 1'b1;
        req_data  = d;
        req_force = f;
        wait_ready(ok);
        if (ok) push_exp(d, f);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    // Keep req_valid high with churning data; only the accept-cycle data may count.
    task automatic hold_chain(input int n);
        bit ok;
        bit prev_done;
        @(posedge clock); #1;
        req_valid = 1'b1;
        req_data  = W'($urandom);
        req_force = ($urandom_range(0, 3) == 0);
        wait_ready(ok);
        if (ok) push_exp(req_data, req_force);
        for (int k = 1; k < n; k++) begin
            prev_done = 0;
            ok = 0;
            for (int i = 0; i < 64 && !ok; i++) begin
                @(posedge clock); #1;
                req_data  = W'($urandom);
                req_force = ($urandom_range(0, 3) == 0);
                @(negedge clock);
                if (req_ready) begin
                    ok = 1;
                    chk("b2b_accept_after_done", 32'(prev_done), 1);
                    push_exp(req_data, req_force);
                end else begin
                    prev_done = done;
                end
            end
            if (!ok) chk("hold_ready_timeout", 0, 1);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && req_ready) return;
        end
        chk("drain_timeout", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sr_s"}, 32'(sr_s), 0);
        chk({tag, "_sr_r"}, 32'(sr_r), 0);
        chk({tag, "_sr_e"}, 32'(sr_e), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_shadow"}, 32'(shadow_q), 0);
    endtask

    initial begin
        bit ok;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        req_force = 1'b0;
        m_shadow  = '0;
        repeat (2) @(negedge clock);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clock);
        chk("por_ready", 32'(req_ready), 1);

        send(4'b1010, 1'b0); wait_drain();
        send(4'b0010, 1'b0); wait_drain();
        send(4'b0010, 1'b0); wait_drain();
        send(4'b0010, 1'b1); wait_drain();
        hold_chain(3);       wait_drain();

        // Abort during the strobe of lane 2.
        @(posedge clock); #1;
        req_valid = 1'b1;
        req_data  = 4'b0101;
        req_force = 1'b1;
        wait_ready(ok);
        @(posedge clock); #1;
        req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            if (sr_e[2]) ok = 1;
        end
        chk("reach_lane2_strobe", 32'(ok), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        chk("mid_reset_ready", 32'(req_ready), 1);
        exp_q.delete();
        m_shadow = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("post_reset_ready", 32'(req_ready), 1);
        chk("post_reset_shadow", 32'(shadow_q), 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                hold_chain(int'($urandom_range(2, 4)));
            end else begin
                send(W'($urandom), ($urandom_range(0, 3) == 0));
                repeat ($urandom_range(0, 3)) @(posedge clock);
            end
            wait_drain();
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
